// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(7,4) transmit and receive chains.
// Bit positions, serializer states and the reference encoder.
package hamming_pkg;

  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int PG = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] hamming_encode(input logic [3:0] d);
    logic [7:0] c;
    c     = '0;
    c[P1] = d[0] ^ d[1] ^ d[3];
    c[P2] = d[0] ^ d[2] ^ d[3];
    c[D0] = d[0];
    c[P4] = d[1] ^ d[2] ^ d[3];
    c[D1] = d[1];
    c[D2] = d[2];
    c[D3] = d[3];
    c[PG] = ^c[6:0];
    return c;
  endfunction

endpackage

// File: rtl/hamming_enc_comb.sv
// Combinational SECDED encoder with a single-bit fault-injection mask.
// The flip is applied after the global parity so it shows up as one error.
module hamming_enc_comb
  import hamming_pkg::*;
(
  input  logic [3:0] data_i,
  input  logic [3:0] err_pos_i,
  output logic [7:0] code_o
);

  logic [7:0] mask;

  always_comb begin
    mask = '0;
    if (err_pos_i != 4'd0 && err_pos_i <= 4'd8) begin
      mask = 8'd1 << (err_pos_i - 4'd1);
    end
  end

  assign code_o = hamming_encode(data_i) ^ mask;

endmodule

// File: rtl/codificador_hamming_tx.sv
// Hamming codeword transmitter: accepts a nibble, encodes it and
// serializes it as start, 8 data bits LSB first, stop.
module codificador_hamming_tx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] err_pos,
  output logic [7:0] codeword,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    cw_q, cw_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [7:0]    enc;
  logic          baud_last;

  hamming_enc_comb u_enc (
    .data_i   (data_in),
    .err_pos_i(err_pos),
    .code_o   (enc)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  // tx_d carries the level of the upcoming cycle so the line is a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cw_d    = cw_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          state_d = START;
          baud_d  = '0;
          idx_d   = '0;
          shreg_d = enc;
          cw_d    = enc;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          state_d = IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      cw_q    <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      cw_q    <= cw_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign codeword = cw_q;
  assign tx_out   = tx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Directed bench for codificador_hamming_tx: codeword table, serial framing,
// handshake corners, async reset and an all-pattern loopback decode.
module tb_codificador_hamming_tx;

  localparam int C = 4;
  localparam int FL = 10 * C;

  typedef struct {
    logic [3:0] d;
    logic [3:0] e;
    logic [7:0] cw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] err_pos;
  logic [7:0] codeword;
  logic       tx_out;
  logic       busy;
  logic       done;

  logic [3:0] data1;
  logic       valid1;
  logic       ready1;
  logic [3:0] err1;
  logic [7:0] cw1;
  logic       tx1;
  logic       busy1;
  logic       done1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  codificador_hamming_tx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .err_pos (err_pos),
    .codeword(codeword),
    .tx_out  (tx_out),
    .busy    (busy),
    .done    (done)
  );

  codificador_hamming_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .data_in (data1),
    .in_valid(valid1),
    .in_ready(ready1),
    .err_pos (err1),
    .codeword(cw1),
    .tx_out  (tx1),
    .busy    (busy1),
    .done    (done1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic int decode(input logic [7:0] r);
    logic [2:0] syn;
    syn[0] = r[0] ^ r[2] ^ r[4] ^ r[6];
    syn[1] = r[1] ^ r[2] ^ r[5] ^ r[6];
    syn[2] = r[3] ^ r[4] ^ r[5] ^ r[6];
    if (!(^r)) return 0;
    if (syn == 3'd0) return 8;
    return int'(syn);
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("wait_ready");
  endtask

  task automatic accept(input logic [3:0] d, input logic [3:0] e);
    wait_ready();
    data_in  = d;
    err_pos  = e;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeout(name);
  endtask

  // Accept one nibble, record the whole frame, recover the data bits mid-bit
  task automatic send_frame(input logic [3:0] d, input logic [3:0] e,
                            output logic [7:0] rx, output logic [7:0] cw0,
                            output int glitch, output int ndone,
                            output int donek, output int nrdy,
                            output logic [1:0] ends);
    logic s[FL];
    logic [9:0] bits;
    accept(d, e);
    glitch = 0;
    ndone  = 0;
    donek  = -1;
    nrdy   = 0;
    bits   = '0;
    cw0    = '0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      s[k] = tx_out;
      if (k % C == C / 2) bits[k / C] = tx_out;
      if (k == 0) cw0 = codeword;
      if (done) begin
        ndone++;
        donek = k;
      end
      if (in_ready) nrdy++;
    end
    for (int k = 0; k < FL; k++) begin
      if (s[k] !== bits[k / C]) glitch++;
    end
    rx   = bits[8:1];
    ends = {bits[9], bits[0]};
  endtask

  task automatic run_vec(input string name, input logic [3:0] d,
                         input logic [3:0] e, input logic [7:0] exp);
    logic [7:0] rx;
    logic [7:0] cw0;
    logic [1:0] ends;
    int gl;
    int nd;
    int dk;
    int nr;
    send_frame(d, e, rx, cw0, gl, nd, dk, nr, ends);
    chk({name, "_cw_at_accept"}, cw0, exp);
    chk({name, "_serial"}, rx, exp);
    chk({name, "_start_stop"}, ends, 2'b10);
    chk({name, "_hold"}, gl, 0);
    chk({name, "_done_cnt"}, nd, 1);
    chk({name, "_done_at"}, dk, FL - 1);
    chk({name, "_ready_low"}, nr, 0);
    @(negedge clk);
    chk({name, "_ready_after"}, in_ready, 1'b1);
    chk({name, "_cw_held"}, codeword, exp);
  endtask

  initial begin
    vec_t vt[10];
    logic [7:0] rx;
    logic [7:0] cw0;
    logic [1:0] ends;
    logic [9:0] seq1;
    logic [9:0] dn1;
    logic [9:0] exp1;
    int gl;
    int nd;
    int dk;
    int nr;
    int t1;
    int t2;
    int td;
    int phase;
    int lb_bad;

    vt[0] = '{4'b1011, 4'd0,  8'h55};
    vt[1] = '{4'b0001, 4'd0,  8'h87};
    vt[2] = '{4'b1111, 4'd0,  8'hFF};
    vt[3] = '{4'b0000, 4'd0,  8'h00};
    vt[4] = '{4'b1011, 4'd3,  8'h51};
    vt[5] = '{4'b1011, 4'd8,  8'hD5};
    vt[6] = '{4'b1011, 4'd12, 8'h55};
    vt[7] = '{4'b1011, 4'd1,  8'h54};
    vt[8] = '{4'b0000, 4'd8,  8'h80};
    vt[9] = '{4'b0110, 4'd15, 8'h33};

    rst      = 1'b1;
    data_in  = '0;
    in_valid = 1'b0;
    err_pos  = '0;
    data1    = '0;
    valid1   = 1'b0;
    err1     = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1'b1);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cw", codeword, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i].d, vt[i].e, vt[i].cw);
    end

    // back-to-back with in_valid held high
    wait_ready();
    data_in  = 4'b0001;
    err_pos  = 4'd0;
    in_valid = 1'b1;
    t1 = -1;
    t2 = -1;
    td = -1;
    phase = 0;
    for (int n = 0; n < 300 && t2 < 0; n++) begin
      @(negedge clk);
      if (phase == 0 && busy) begin
        t1 = cyc;
        phase = 1;
        chk("b2b_cw1", codeword, 8'h87);
        data_in = 4'b1111;
      end else if (phase == 1 && done) begin
        td = cyc;
      end else if (phase == 1 && !busy) begin
        phase = 2;
      end else if (phase == 2 && busy) begin
        t2 = cyc;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (t2 < 0) begin
      timeout("b2b_second_accept");
    end else begin
      chk("b2b_done_at", td - t1, FL - 1);
      chk("b2b_gap", t2 - t1, FL + 1);
      chk("b2b_cw2", codeword, 8'hFF);
    end
    wait_done("b2b_done2");
    @(negedge clk);

    // in_valid pulsed mid-frame is ignored
    accept(4'b1011, 4'd0);
    repeat (15) @(negedge clk);
    data_in  = 4'b0000;
    err_pos  = 4'd5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_cw", codeword, 8'h55);
    chk("mid_busy", busy, 1'b1);
    wait_done("mid_done");
    @(negedge clk);
    @(negedge clk);
    chk("mid_no_restart", busy, 1'b0);
    chk("mid_cw_after", codeword, 8'h55);

    // asynchronous reset in the middle of DATA
    accept(4'b1011, 4'd0);
    repeat (2 * C + 3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_tx", tx_out, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cw", codeword, 8'h00);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec("post_rst", 4'b0001, 4'd0, 8'h87);

    // one cycle per bit
    @(negedge clk);
    data1  = 4'b1011;
    err1   = 4'd0;
    valid1 = 1'b1;
    @(posedge clk);
    #1 valid1 = 1'b0;
    seq1 = '0;
    dn1  = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seq1[k] = tx1;
      dn1[k]  = done1;
    end
    exp1 = {1'b1, 8'h55, 1'b0};
    chk("c1_serial", seq1, exp1);
    chk("c1_done", dn1, 10'h200);
    chk("c1_cw", cw1, 8'h55);
    @(negedge clk);
    chk("c1_ready", ready1, 1'b1);

    // loopback through a bench-side SECDED decoder
    lb_bad = 0;
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e <= 8; e++) begin
        send_frame(4'(d), 4'(e), rx, cw0, gl, nd, dk, nr, ends);
        chk($sformatf("loop_d%0d_e%0d", d, e), decode(rx), e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codificador_hamming_tx.md
# codificador_hamming_tx

- Transmit-side counterpart of the SECDED error-position decoder.
- Accepts a 4-bit nibble over a valid/ready handshake and encodes it into an 8-bit extended Hamming(7,4) codeword (Hamming(7,4) plus a global parity bit).
- Can optionally flip one selected codeword bit for fault-injection testing.
- Shifts the codeword out on a single serial line in a start/8-data/stop frame.
- Sits between the data source and the channel; the receive chain recomputes the syndromes that feed the decoder.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit, legal range ≥ 1.

Ports:
- `clk` input, 1 bit: single system clock, rising-edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `data_in` input, 4 bits: nibble to encode (d3..d0).
- `in_valid` input, 1 bit: `data_in` is valid.
- `in_ready` output, 1 bit: block can accept a nibble; high only in IDLE.
- `err_pos` input, 4 bits: fault injection. 0 means no error; 1..8 flips codeword bit (err_pos−1); 9..15 are treated as 0. Sampled at the accept edge.
- `codeword` output, 8 bits: registered codeword as transmitted, including any injected error.
- `tx_out` output, 1 bit: serial line, idles high.
- `busy` output, 1 bit: a frame is in progress.
- `done` output, 1 bit: one-cycle pulse at frame end.

## Operation

Codeword layout (bit index = Hamming position − 1):
- [0] = p1 = d0^d1^d3
- [1] = p2 = d0^d2^d3
- [2] = d0
- [3] = p4 = d1^d2^d3
- [4] = d1
- [5] = d2
- [6] = d3
- [7] = pg = XOR of [6:0]

Error injection:
- Applied after pg is computed, so a single flip yields the syndromes the decoder expects.
- Flipping bit 7 produces a pure global-parity error.

Accept and frame format:
- Accept occurs on a rising edge with `in_valid && in_ready`.
- At accept, `codeword` and the shift register load together.
- Frame on `tx_out`: start bit 0, then `codeword`[0]..[7] LSB first, then stop bit 1.

FSM states:
- IDLE: `tx_out`=1, `in_ready`=1, `busy`=0. On accept → START.
- START: `tx_out`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: `tx_out` = current shift bit, held CLKS_PER_BIT cycles per bit. A 3-bit index counts 0..7; after bit 7 → STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles → IDLE. `done` pulses in the last STOP cycle.

Counters:
- The baud counter spans 0..CLKS_PER_BIT−1, width $clog2(CLKS_PER_BIT) with a minimum of 1.
- The baud counter clears on every state change.

Control behaviour:
- `in_valid` outside IDLE is ignored; the source must hold the nibble until accepted.
- `codeword` holds its value until the next accept.

Reset (asynchronous, at any time including mid-frame):
- State returns to IDLE and the line is immediately idle.
- `tx_out`=1, `in_ready`=1, `busy`=0, `done`=0, `codeword`=8'h00, all counters 0.

## Timing

- Accept at edge N: `codeword` valid and `tx_out`=0 from edge N (registered).
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- `done` is high during cycle N+10·CLKS_PER_BIT−1.
- `in_ready` rises at edge N+10·CLKS_PER_BIT.
- Back-to-back operation: with `in_valid` held high, the next accept happens on the first IDLE edge, so each frame costs 10·CLKS_PER_BIT + 1 cycles.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle; no special-casing is needed.
- All outputs are registered; there are no combinational paths from input to output.

## Structure

- Shared package `hamming_pkg`:
  - bit-index localparams (P1, P2, D0, P4, D1, D2, D3, PG);
  - FSM state enum `tx_state_t` {IDLE, START, DATA, STOP};
  - function `hamming_encode(logic [3:0]) -> logic [7:0]`, to be reused by the receive chain for reference syndromes.
- Sub-module `hamming_enc_comb`: purely combinational encoder plus injection mask. The FSM/serializer stays in the top module.

## Test plan

1. Reset then data_in=4'b1011, err_pos=0, CLKS_PER_BIT=4 → `codeword`=8'h55; `tx_out` sequence 0,1,0,1,0,1,0,1,0,1 with 4 cycles each; `done` at cycle 39 after accept.
2. data_in=4'b0001 → 8'h87; data_in=4'b1111 → 8'hFF; data_in=4'b0000 → 8'h00 (pg correctness).
3. data_in=4'b1011 with err_pos=3 → 8'h51; err_pos=8 → 8'hD5; err_pos=12 → 8'h55.
4. `in_valid` held high with two nibbles → second accept exactly 1 cycle after the first `done`; `in_valid` pulsed mid-frame is ignored and `codeword` is unchanged.
5. Assert `rst` mid-DATA → same cycle `tx_out`=1, `busy`=0, `codeword`=8'h00; next accept starts a clean frame.
6. Loopback: a bench deserializer computes syndromes and feeds the decoder for all 16 nibbles × err_pos 0..8 → `pos_error` equals injected position (0 for none).
